// File: rtl/led_display_row_fetch_if.sv
// RAM read bus and assembled-row stream shared by the row fetcher and its neighbours.
// The master side is the fetcher: it drives RAM reads and presents rows.
interface led_display_row_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ROW_W  = 384,
  parameter int unsigned ROW_AW = 4
);
  logic [ADDR_W-1:0] ram_address_out;
  logic              ram_rd_en_out;
  logic [31:0]       ram_rdata_in;
  logic [ROW_W-1:0]  row_out;
  logic              row_valid_out;
  logic [ROW_AW-1:0] row_address_out;
  logic              row_ready_in;

  modport master (
    output ram_address_out, ram_rd_en_out,
    input  ram_rdata_in,
    output row_out, row_valid_out, row_address_out,
    input  row_ready_in
  );

  modport slave (
    input  ram_address_out, ram_rd_en_out,
    output ram_rdata_in,
    input  row_out, row_valid_out, row_address_out,
    output row_ready_in
  );
endinterface

// File: rtl/led_display_row_fetch.sv
// Fetches display rows word by word from a pipelined RAM and presents them as
// whole rows, prefetching the next row while the current one waits at the output.
module led_display_row_fetch #(
  parameter int unsigned WORDS_PER_ROW = 12,
  parameter int unsigned ROWS          = 16,
  parameter int unsigned RAM_LATENCY   = 2,
  parameter int unsigned ADDR_W        = 32,
  localparam int unsigned ROW_AW       = $clog2(ROWS),
  localparam int unsigned ROW_W        = 32 * WORDS_PER_ROW
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [ADDR_W-1:0]    frame_base_in,
  input  logic                 frame_swap_in,
  output logic                 frame_swap_done_out,
  led_display_row_fetch_if.master bus
);
  localparam int unsigned WCW = $clog2(WORDS_PER_ROW + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FULL} state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      base;
  logic                   swap_pending;
  logic [ROW_AW-1:0]      fetch_row;
  logic [ROW_AW-1:0]      asm_row;
  logic [WCW-1:0]         issue_cnt;
  logic [WCW-1:0]         cap_cnt;
  logic [RAM_LATENCY-1:0] strobe_dly;
  logic [ROW_W-1:0]       asm_buf;

  logic                   take_swap;
  logic                   capture;
  logic                   xfer;
  logic [ADDR_W-1:0]      start_addr;

  always_comb begin
    take_swap  = (state == S_IDLE) && (fetch_row == '0) && (swap_pending || frame_swap_in);
    capture    = strobe_dly[RAM_LATENCY-1];
    xfer       = (state == S_FULL) && (!bus.row_valid_out || bus.row_ready_in);
    start_addr = (take_swap ? frame_base_in : base)
               + ADDR_W'(fetch_row) * ADDR_W'(WORDS_PER_ROW);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state               <= S_IDLE;
      base                <= frame_base_in;
      swap_pending        <= 1'b0;
      fetch_row           <= '0;
      asm_row             <= '0;
      issue_cnt           <= '0;
      cap_cnt             <= '0;
      strobe_dly          <= '0;
      asm_buf             <= '0;
      frame_swap_done_out <= 1'b0;
      bus.ram_address_out <= '0;
      bus.ram_rd_en_out   <= 1'b0;
      bus.row_out         <= '0;
      bus.row_valid_out   <= 1'b0;
      bus.row_address_out <= '0;
    end else begin
      frame_swap_done_out <= 1'b0;
      strobe_dly          <= (strobe_dly << 1) | RAM_LATENCY'(bus.ram_rd_en_out);

      // Words enter at the LSB end so the first-fetched word ends up at the MSB end.
      if (capture) begin
        asm_buf <= (asm_buf << 32) | ROW_W'(bus.ram_rdata_in);
        cap_cnt <= (cap_cnt == WCW'(WORDS_PER_ROW - 1)) ? '0 : cap_cnt + WCW'(1);
      end

      if (take_swap) begin
        base                <= frame_base_in;
        swap_pending        <= 1'b0;
        frame_swap_done_out <= 1'b1;
      end else if (frame_swap_in) begin
        swap_pending <= 1'b1;
      end

      if (xfer) begin
        bus.row_out         <= asm_buf;
        bus.row_address_out <= asm_row;
        bus.row_valid_out   <= 1'b1;
      end else if (bus.row_ready_in) begin
        bus.row_valid_out <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          state               <= S_ISSUE;
          bus.ram_rd_en_out   <= 1'b1;
          bus.ram_address_out <= start_addr;
          issue_cnt           <= '0;
          asm_row             <= fetch_row;
        end
        S_ISSUE: begin
          if (issue_cnt == WCW'(WORDS_PER_ROW - 1)) begin
            state             <= S_DRAIN;
            bus.ram_rd_en_out <= 1'b0;
            fetch_row         <= (fetch_row == ROW_AW'(ROWS - 1)) ? '0 : fetch_row + ROW_AW'(1);
          end else begin
            issue_cnt           <= issue_cnt + WCW'(1);
            bus.ram_address_out <= bus.ram_address_out + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (capture && (cap_cnt == WCW'(WORDS_PER_ROW - 1))) state <= S_FULL;
        end
        S_FULL: begin
          if (xfer) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_display_row_fetch.sv
// Randomized bench for led_display_row_fetch: a RAM model feeds the DUT and a
// row-level reference model predicts every read address, swap pulse and output row.
module tb_led_display_row_fetch;
  localparam int unsigned WPR         = 12;
  localparam int unsigned ROWS        = 16;
  localparam int unsigned LAT         = 2;
  localparam int unsigned ROW_W       = 32 * WPR;
  localparam int unsigned FIRST_VALID = WPR + LAT + 2;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [31:0] frame_base_in = 32'h100;
  logic        frame_swap_in = 1'b0;
  logic        frame_swap_done_out;
  logic        done_b;

  always #5 clk_in = ~clk_in;

  led_display_row_fetch_if #(.ADDR_W(32), .ROW_W(ROW_W), .ROW_AW(4)) bus ();
  led_display_row_fetch_if #(.ADDR_W(32), .ROW_W(32), .ROW_AW(1)) bus_b ();

  led_display_row_fetch #(.WORDS_PER_ROW(WPR), .ROWS(ROWS), .RAM_LATENCY(LAT), .ADDR_W(32)) dut (
    .clk_in              (clk_in),
    .reset_in            (reset_in),
    .frame_base_in       (frame_base_in),
    .frame_swap_in       (frame_swap_in),
    .frame_swap_done_out (frame_swap_done_out),
    .bus                 (bus)
  );

  led_display_row_fetch #(.WORDS_PER_ROW(1), .ROWS(2), .RAM_LATENCY(4), .ADDR_W(32)) dut_b (
    .clk_in              (clk_in),
    .reset_in            (reset_in),
    .frame_base_in       (32'h40),
    .frame_swap_in       (1'b0),
    .frame_swap_done_out (done_b),
    .bus                 (bus_b)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // RAM: data for the address sampled with the strobe appears LAT cycles later.
  logic [31:0] pipe_a [LAT];
  logic [31:0] pipe_b [4];
  always @(posedge clk_in) begin
    pipe_a[0] <= bus.ram_address_out;
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= bus_b.ram_address_out;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign bus.ram_rdata_in   = mem_word(pipe_a[LAT-1]);
  assign bus_b.ram_rdata_in = mem_word(pipe_b[3]);
  assign bus_b.row_ready_in = 1'b1;

  typedef struct packed {
    logic [3:0]       idx;
    logic [ROW_W-1:0] data;
  } row_t;

  row_t             exp_rows[$];
  int unsigned      strobes = 0;
  int unsigned      cyc = 0;
  int unsigned      rst_cycles = 0;
  logic [31:0]      frame_base = '0;
  logic [31:0]      pend_base = '0;
  bit               pending = 1'b0;
  bit               seen_first = 1'b0;
  bit               held = 1'b0;
  logic [ROW_W-1:0] build = '0;

  // Reference: the k-th read since reset targets word k%WPR of row (k/WPR)%ROWS of the current frame.
  always @(negedge clk_in) begin
    int unsigned word;
    int unsigned row;
    logic [31:0] exp_addr;
    logic        exp_done;
    if (reset_in) begin
      if (rst_cycles > 0) begin
        check_eq("rst_rd_en", bus.ram_rd_en_out, 0);
        check_eq("rst_valid", bus.row_valid_out, 0);
        check_eq("rst_row", bus.row_out, 0);
        check_eq("rst_done", frame_swap_done_out, 0);
      end
      rst_cycles++;
      strobes    = 0;
      cyc        = 0;
      pending    = 1'b0;
      seen_first = 1'b0;
      held       = 1'b0;
      build      = '0;
      frame_base = frame_base_in;
      exp_rows.delete();
    end else begin
      rst_cycles = 0;
      if (bus.ram_rd_en_out) begin
        word     = strobes % WPR;
        row      = (strobes / WPR) % ROWS;
        exp_done = 1'b0;
        if (word == 0 && row == 0 && pending) begin
          frame_base = pend_base;
          pending    = 1'b0;
          exp_done   = 1'b1;
        end
        exp_addr = frame_base + 32'(row * WPR + word);
        check_eq("swap_done", frame_swap_done_out, exp_done);
        check_eq("ram_addr", bus.ram_address_out, exp_addr);
        build = (build << 32) | ROW_W'(mem_word(exp_addr));
        if (word == WPR - 1) exp_rows.push_back('{idx: 4'(row), data: build});
        strobes++;
      end else begin
        check_eq("swap_done_quiet", frame_swap_done_out, 0);
      end

      if (held) check_eq("valid_held", bus.row_valid_out, 1);
      if (bus.row_valid_out) begin
        if (!seen_first) begin
          check_eq("first_valid_cyc", cyc, FIRST_VALID);
          seen_first = 1'b1;
        end
        check_eq("row_queued", exp_rows.size() > 0, 1);
        if (exp_rows.size() > 0) begin
          check_eq("row_addr", bus.row_address_out, exp_rows[0].idx);
          check_eq("row_data", bus.row_out, exp_rows[0].data);
          if (bus.row_ready_in) void'(exp_rows.pop_front());
        end
      end
      held = bus.row_valid_out && !bus.row_ready_in;

      if (frame_swap_in) begin
        pending   = 1'b1;
        pend_base = frame_base_in;
      end
      cyc++;
    end
  end

  // Small configuration: one word per row, two rows, ready always high.
  int unsigned cyc_b = 0;
  int unsigned k_b = 0;
  bit          seen_b = 1'b0;
  always @(negedge clk_in) begin
    if (reset_in) begin
      cyc_b  = 0;
      k_b    = 0;
      seen_b = 1'b0;
    end else begin
      if (bus_b.row_valid_out) begin
        if (!seen_b) begin
          check_eq("b_first_valid_cyc", cyc_b, 7);
          seen_b = 1'b1;
        end
        check_eq("b_row_addr", bus_b.row_address_out, k_b % 2);
        check_eq("b_row_data", bus_b.row_out, mem_word(32'h40 + (k_b % 2)));
        k_b++;
      end
      cyc_b++;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  initial begin
    int unsigned n;
    int unsigned dc;
    bit          sent;
    bit          found;

    bus.row_ready_in = 1'b0;
    reset_in         = 1'b1;
    frame_base_in    = 32'h100;
    repeat (3) tick();
    reset_in = 1'b0;

    // Stall the consumer after the first row: only row 1 may be prefetched.
    n = 0;
    while (!bus.row_valid_out && n < 200) begin
      tick();
      n++;
    end
    check_eq("first_valid_seen", bus.row_valid_out, 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.ram_rd_en_out) n++;
    end
    check_eq("stall_reads", n, WPR);
    check_eq("stall_rd_idle", bus.ram_rd_en_out, 0);
    check_eq("stall_row_addr", bus.row_address_out, 0);

    // Ready high through several frames; swap to 0x800 requested during row 5 of frame 2.
    bus.row_ready_in = 1'b1;
    n    = 0;
    dc   = 0;
    sent = 1'b0;
    while (strobes < (3 * ROWS + 1) * WPR && n < 5000) begin
      tick();
      n++;
      frame_swap_in = 1'b0;
      if (frame_swap_done_out) begin
        dc++;
        check_eq("swap_first_addr", bus.ram_address_out, 32'h800);
      end
      if (!sent && bus.ram_rd_en_out && (strobes / WPR) == 2 * ROWS + 5) begin
        frame_base_in = 32'h800;
        frame_swap_in = 1'b1;
        sent          = 1'b1;
      end
    end
    frame_swap_in = 1'b0;
    check_eq("swap_done_count", dc, 1);

    // Random backpressure and random swaps, including bases that wrap the address space.
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.row_ready_in = ($urandom_range(0, 3) != 0);
      frame_swap_in    = 1'b0;
      if (bus.ram_rd_en_out && ((strobes / WPR) % ROWS) >= 2 && ((strobes / WPR) % ROWS) <= 13
          && $urandom_range(0, 99) == 0) begin
        frame_base_in = $urandom;
        frame_swap_in = 1'b1;
      end
    end
    frame_swap_in    = 1'b0;
    bus.row_ready_in = 1'b1;

    // Reset while row 3 is being issued; the bench restarts its model at row 0.
    n     = 0;
    found = 1'b0;
    while (!found && n < 3000) begin
      tick();
      n++;
      if (bus.ram_rd_en_out && ((strobes / WPR) % ROWS) == 3) found = 1'b1;
    end
    check_eq("row3_issue_seen", found, 1);
    repeat (3) tick();
    reset_in = 1'b1;
    repeat (2) tick();
    reset_in = 1'b0;
    repeat (300) tick();
    check_eq("post_reset_rows", seen_first, 1);
    check_eq("b_rows_seen", k_b > 10, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
